// File: rtl/div_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// div_sequencer_pkg
//   Shared types for the EX-stage divide controller.
//   - div_op_t    : divide-class opcode (DIV, DIVU, REM, REMU)
//   - div_state_t : controller FSM states (IDLE, CALC, DONE)
//   - op_is_signed / op_is_rem : opcode decode helpers
// ---------------------------------------------------------------------------
package div_sequencer_pkg;

    localparam int DIV_XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } div_state_t;

    function automatic logic op_is_signed(input div_op_t op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_is_rem(input div_op_t op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// ---------------------------------------------------------------------------
// div_sequencer_if
//   EX-stage / hazard-unit side bundle of the divide controller.
//   master : pipeline side (drives operation, operands, flush; sees results)
//   slave  : divide controller
//   Signals: valid_e, op_e, srca_e, srcb_e, flush_e (to divider);
//            stall_req, busy, result_valid, result (from divider).
// ---------------------------------------------------------------------------
interface div_sequencer_if
    import div_sequencer_pkg::*;
#(
    parameter int XLEN = DIV_XLEN_DEFAULT
);
    logic             valid_e;
    div_op_t          op_e;
    logic [XLEN-1:0]  srca_e;
    logic [XLEN-1:0]  srcb_e;
    logic             flush_e;
    logic             stall_req;
    logic             busy;
    logic             result_valid;
    logic [XLEN-1:0]  result;

    modport master (
        output valid_e, op_e, srca_e, srcb_e, flush_e,
        input  stall_req, busy, result_valid, result
    );

    modport slave (
        input  valid_e, op_e, srca_e, srcb_e, flush_e,
        output stall_req, busy, result_valid, result
    );
endinterface

// File: rtl/div_sequencer_div_step.sv
// ---------------------------------------------------------------------------
// div_step
//   One combinational radix-2 restoring division iteration.
//   rem_in       : partial remainder (always < divisor)
//   dividend_bit : next dividend bit, MSB first
//   divisor      : divisor magnitude
//   rem_out      : next partial remainder
//   q_bit        : quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);
    // One extra bit so the shifted remainder and the borrow both fit.
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        shifted = {rem_in, dividend_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[XLEN];
        // No borrow: keep the difference; otherwise restore.
        rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end
endmodule

// File: rtl/div_sequencer.sv
// ---------------------------------------------------------------------------
// div_sequencer
//   Multi-cycle DIV/DIVU/REM/REMU controller for the EX stage. Runs a
//   restoring divider one quotient bit per cycle on operand magnitudes and
//   applies sign fix-up when the result is registered. Holds stall_req high
//   from the accept cycle until the result is ready; flush_e or !start
//   abort the operation and drop stall_req in the same cycle.
//
//   Ports:
//     clk    : core clock, rising edge
//     rst_n  : asynchronous active-low reset
//     start  : core run enable; low forces IDLE
//     bus    : div_sequencer_if.slave (operation in, stall/result out)
//
//   Build option:
//     DIV_EARLY_OUT_EN : when defined, |dividend| < |divisor| finishes in
//                        one stall cycle (quotient 0, remainder = dividend).
// ---------------------------------------------------------------------------
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN = DIV_XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    div_sequencer_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t       state_reg, state_next;
    logic [CW-1:0]    count_reg;
    div_op_t          op_reg;
    logic             sign_a_reg, sign_b_reg;
    logic [XLEN-1:0]  divisor_reg;
    logic [XLEN-1:0]  dq_reg;        // dividend bits shift out, quotient bits shift in
    logic [XLEN-1:0]  rem_reg;
    logic [XLEN-1:0]  result_reg;

    logic             run_ok;
    logic             in_signed, a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic             is_special;
    logic [XLEN-1:0]  special_result;
    logic [XLEN-1:0]  step_rem;
    logic             step_q;
    logic [XLEN-1:0]  q_final, quo_fixed, rem_fixed, fixed_result;
    logic             load_op, step_en, load_result;
    logic [XLEN-1:0]  result_next;
    logic             stall_req, result_valid;

    // ---------------- operand decode in the accept cycle -----------------
    assign run_ok    = start && !bus.flush_e;
    assign in_signed = op_is_signed(bus.op_e);
    assign a_neg     = in_signed && bus.srca_e[XLEN-1];
    assign b_neg     = in_signed && bus.srcb_e[XLEN-1];
    assign a_mag     = a_neg ? -bus.srca_e : bus.srca_e;
    assign b_mag     = b_neg ? -bus.srcb_e : bus.srcb_e;

    // Cases resolved without iterating; their results are already final,
    // so they bypass the sign fix-up.
    always_comb begin
        is_special     = 1'b0;
        special_result = '0;
        if (bus.srcb_e == '0) begin
            is_special     = 1'b1;
            special_result = op_is_rem(bus.op_e) ? bus.srca_e : '1;
        end else if (in_signed && (bus.srca_e == MIN_NEG) && (bus.srcb_e == '1)) begin
            is_special     = 1'b1;
            special_result = op_is_rem(bus.op_e) ? '0 : MIN_NEG;
        end
`ifdef DIV_EARLY_OUT_EN
        else if (a_mag < b_mag) begin
            is_special     = 1'b1;
            special_result = op_is_rem(bus.op_e) ? bus.srca_e : '0;
        end
`endif
    end

    // ---------------- iteration datapath ---------------------------------
    div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in       (rem_reg),
        .dividend_bit (dq_reg[XLEN-1]),
        .divisor      (divisor_reg),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    // Final-iteration values feed the fix-up directly so result is
    // registered on the edge into DONE.
    assign q_final      = {dq_reg[XLEN-2:0], step_q};
    assign quo_fixed    = (sign_a_reg ^ sign_b_reg) ? -q_final : q_final;
    assign rem_fixed    = sign_a_reg ? -step_rem : step_rem;
    assign fixed_result = op_is_rem(op_reg) ? rem_fixed : quo_fixed;

    // ---------------- FSM: state register --------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state and controls -----------------------
    always_comb begin
        state_next   = state_reg;
        stall_req    = 1'b0;
        result_valid = 1'b0;
        load_op      = 1'b0;
        step_en      = 1'b0;
        load_result  = 1'b0;
        result_next  = result_reg;
        if (!run_ok) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.valid_e) begin
                        stall_req = 1'b1;
                        load_op   = 1'b1;
                        if (is_special) begin
                            state_next  = DONE;
                            load_result = 1'b1;
                            result_next = special_result;
                        end else begin
                            state_next = CALC;
                        end
                    end
                end
                CALC: begin
                    stall_req = 1'b1;
                    step_en   = 1'b1;
                    if (count_reg == '0) begin
                        state_next  = DONE;
                        load_result = 1'b1;
                        result_next = fixed_result;
                    end
                end
                DONE: begin
                    result_valid = 1'b1;
                    state_next   = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // ---------------- operand, counter and result registers -------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg   <= '0;
            op_reg      <= DIV;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            divisor_reg <= '0;
            dq_reg      <= '0;
            rem_reg     <= '0;
            result_reg  <= '0;
        end else begin
            if (load_op) begin
                op_reg      <= bus.op_e;
                sign_a_reg  <= a_neg;
                sign_b_reg  <= b_neg;
                divisor_reg <= b_mag;
                dq_reg      <= a_mag;
                rem_reg     <= '0;
                count_reg   <= CW'(XLEN - 1);
            end else if (step_en) begin
                rem_reg <= step_rem;
                dq_reg  <= q_final;
                if (count_reg != '0) begin
                    count_reg <= count_reg - 1'b1;
                end
            end
            if (load_result) begin
                result_reg <= result_next;
            end
        end
    end

    assign bus.stall_req    = stall_req;
    assign bus.busy         = (state_reg == CALC) || (state_reg == DONE);
    assign bus.result_valid = result_valid;
    assign bus.result       = result_reg;

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    localparam int XLEN = 32;
`ifdef DIV_EARLY_OUT_EN
    localparam int EO_ST = 1;
`else
    localparam int EO_ST = XLEN + 1;
`endif
    localparam int FULL = XLEN + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] exp_last = '0;

    div_sequencer_if #(.XLEN(XLEN)) bus ();

    div_sequencer #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        div_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          stalls;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model written from the arithmetic definition of each op.
    function automatic logic [31:0] ref_result(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (op)
            DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REMU: return (b == 0) ? a : a % b;
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            default: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
        endcase
    endfunction

    function automatic int ref_stalls(input div_op_t op, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        sgn = (op == DIV) || (op == REM);
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        begin
            logic [31:0] ma;
            logic [31:0] mb;
            ma = (sgn && a[31]) ? -a : a;
            mb = (sgn && b[31]) ? -b : b;
            if (ma < mb) return 1;
        end
`endif
        return FULL;
    endfunction

    // Called with the clock low; presents the op and waits for result_valid.
    task automatic issue(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int stalls, output int done_cyc);
        bit ok;
        check("result_hold_before_op", bus.result, exp_last);
        bus.valid_e = 1'b1;
        bus.op_e    = op;
        bus.srca_e  = a;
        bus.srcb_e  = b;
        stalls   = 0;
        ok       = 1'b0;
        res      = '0;
        done_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bus.stall_req) stalls++;
            if (bus.result_valid) begin
                ok       = 1'b1;
                res      = bus.result;
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        check("result_valid_seen", 32'(ok), 32'd1);
    endtask

    task automatic run_vec(input string name, input div_op_t op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int exp_st,
                           output int done_cyc);
        logic [31:0] res;
        int          st;
        issue(op, a, b, res, st, done_cyc);
        check({name, " result"}, res, exp);
        check({name, " stalls"}, 32'(st), 32'(exp_st));
        exp_last = exp;
        @(negedge clk);
        check({name, " pulse_end"}, 32'(bus.result_valid), 32'd0);
        check({name, " busy_end"}, 32'(bus.busy), 32'd0);
        check({name, " result_stable"}, bus.result, exp);
        $display("op=%s a=0x%08h b=0x%08h -> result=0x%08h stalls=%0d", op.name(), a, b, res, st);
    endtask

    initial begin
        int          dc1, dc2, pulses;
        div_op_t     rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{DIVU, 32'd100,        32'd7,          32'd14,         FULL};
        vecs[1]  = '{REMU, 32'd100,        32'd7,          32'd2,          FULL};
        vecs[2]  = '{DIV,  -32'sd7,        32'd2,          32'hFFFF_FFFD,  FULL};
        vecs[3]  = '{REM,  -32'sd7,        32'd2,          32'hFFFF_FFFF,  FULL};
        vecs[4]  = '{DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
        vecs[5]  = '{REMU, 32'd5,          32'd0,          32'd5,          1};
        vecs[6]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[7]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[8]  = '{DIVU, 32'd3,          32'd10,         32'd0,          EO_ST};
        vecs[9]  = '{DIV,  32'd7,          -32'sd2,        32'hFFFF_FFFD,  FULL};
        vecs[10] = '{REM,  32'd7,          -32'sd2,        32'd1,          FULL};
        vecs[11] = '{DIV,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1};
        vecs[12] = '{REM,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1};
        vecs[13] = '{REM,  -32'sd5,        32'd10,         32'hFFFF_FFFB,  EO_ST};
        vecs[14] = '{DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  FULL};
        vecs[15] = '{DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  FULL};
        vecs[16] = '{REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  EO_ST};
        vecs[17] = '{DIV,  -32'sd100,      -32'sd7,        32'd14,         FULL};

        // ---------------- reset ----------------
        rst_n       = 1'b0;
        start       = 1'b1;
        bus.valid_e = 1'b0;
        bus.op_e    = DIVU;
        bus.srca_e  = '0;
        bus.srcb_e  = '0;
        bus.flush_e = 1'b0;
        #12;
        check("reset stall_req", 32'(bus.stall_req), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset result_valid", 32'(bus.result_valid), 32'd0);
        check("reset result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- directed table ----------------
        for (int i = 0; i < 18; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].exp, vecs[i].stalls, dc1);
        end
        bus.valid_e = 1'b0;
        @(negedge clk);

        // ---------------- flush in the 10th CALC cycle ----------------
        bus.valid_e = 1'b1;
        bus.op_e    = DIVU;
        bus.srca_e  = 32'd1000;
        bus.srcb_e  = 32'd3;
        #1;
        check("flush accept stall", 32'(bus.stall_req), 32'd1);
        for (int i = 0; i < 10; i++) @(negedge clk);
        bus.flush_e = 1'b1;
        #1;
        check("flush stall_gated", 32'(bus.stall_req), 32'd0);
        check("flush no_valid", 32'(bus.result_valid), 32'd0);
        check("flush busy_in_calc", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.flush_e = 1'b0;
        bus.valid_e = 1'b0;
        #1;
        check("flush busy_after", 32'(bus.busy), 32'd0);
        check("flush result_unchanged", bus.result, exp_last);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus.result_valid) pulses++;
        end
        check("flush no_late_pulse", 32'(pulses), 32'd0);
        @(negedge clk);
        run_vec("after_flush DIVU 9/3", DIVU, 32'd9, 32'd3, 32'd3, FULL, dc1);
        bus.valid_e = 1'b0;
        @(negedge clk);

        // ---------------- accept and flush together ----------------
        bus.valid_e = 1'b1;
        bus.op_e    = DIVU;
        bus.srca_e  = 32'd50;
        bus.srcb_e  = 32'd5;
        bus.flush_e = 1'b1;
        #1;
        check("accept+flush stall", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        bus.flush_e = 1'b0;
        bus.valid_e = 1'b0;
        #1;
        check("accept+flush busy", 32'(bus.busy), 32'd0);
        check("accept+flush result", bus.result, exp_last);

        // ---------------- start dropped mid-CALC ----------------
        @(negedge clk);
        bus.valid_e = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge clk);
        start = 1'b0;
        #1;
        check("start_low stall", 32'(bus.stall_req), 32'd0);
        @(negedge clk);
        start       = 1'b1;
        bus.valid_e = 1'b0;
        #1;
        check("start_low busy", 32'(bus.busy), 32'd0);
        check("start_low result", bus.result, exp_last);
        @(negedge clk);

        // ---------------- back-to-back ----------------
        run_vec("b2b DIVU 20/4", DIVU, 32'd20, 32'd4, 32'd5, FULL, dc1);
        run_vec("b2b DIVU 21/5", DIVU, 32'd21, 32'd5, 32'd4, FULL, dc2);
        check("b2b spacing", 32'(dc2 - dc1), 32'd34);
        bus.valid_e = 1'b0;
        @(negedge clk);

        // ---------------- reset mid-CALC ----------------
        bus.valid_e = 1'b1;
        bus.op_e    = DIV;
        bus.srca_e  = 32'd77;
        bus.srcb_e  = 32'd3;
        for (int i = 0; i < 6; i++) @(negedge clk);
        #2;
        rst_n       = 1'b0;
        bus.valid_e = 1'b0;
        #1;
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset stall", 32'(bus.stall_req), 32'd0);
        check("midreset result_valid", 32'(bus.result_valid), 32'd0);
        check("midreset result", bus.result, 32'd0);
        exp_last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- randomized against reference model ----------------
        for (int i = 0; i < 150; i++) begin
            rop = div_op_t'(2'($urandom_range(0, 3)));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin rb = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000; end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = -32'($urandom_range(1, 15));
                4: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 100)); end
                default: rb = $urandom;
            endcase
            run_vec($sformatf("rnd%0d", i), rop, ra, rb, ref_result(rop, ra, rb),
                    ref_stalls(rop, ra, rb), dc1);
        end
        bus.valid_e = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
